// File: rtl/trace_sram_sequencer_if.sv
// Load-port and trace-handshake bundle between the trace sequencer and its users.
// master: the sequencer side; slave: host loader plus cache-simulator side.
interface trace_sram_sequencer_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              trace_valid;
  logic              trace_ready;
  logic [DATA_W-1:0] trace_addr;

  modport master (
    input  load_valid, load_addr, load_data, trace_ready,
    output load_ready, trace_valid, trace_addr
  );

  modport slave (
    output load_valid, load_addr, load_data, trace_ready,
    input  load_ready, trace_valid, trace_addr
  );
endinterface

// File: rtl/trace_sram_sequencer.sv
// Arbitrates the single-port trace SRAM between host loads and in-order playback.
// Playback is RD -> CAP -> VLD per word, so a word is offered every 3 cycles at best.
module trace_sram_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_W:0]      trace_len,
  trace_sram_sequencer_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W:0]      played_count,
  output logic                 sram_csb0,
  output logic                 sram_web0,
  output logic [ADDR_W-1:0]    sram_addr0,
  output logic [DATA_W-1:0]    sram_din0,
  input  logic [DATA_W-1:0]    sram_dout0
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);

  typedef enum logic [2:0] {IDLE, RD, CAP, VLD, DONE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   idx, idx_n, len, len_n, cnt, cnt_n, len_clamp;
  logic               done_r, done_n, capture, load_ready;
  logic [DATA_W-1:0]  word;

  assign len_clamp  = (trace_len > DEPTH_L) ? DEPTH_L : trace_len;
  assign load_ready = ((state == IDLE) || (state == DONE)) && !start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      len    <= '0;
      cnt    <= '0;
      done_r <= 1'b0;
      word   <= '0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      len    <= len_n;
      cnt    <= cnt_n;
      done_r <= done_n;
      if (capture) word <= sram_dout0;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    len_n      = len;
    cnt_n      = cnt;
    done_n     = done_r;
    capture    = 1'b0;
    sram_csb0  = 1'b1;
    sram_web0  = 1'b1;
    sram_addr0 = '0;
    sram_din0  = '0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          cnt_n   = '0;
          idx_n   = '0;
          len_n   = len_clamp;
          done_n  = (len_clamp == '0);
          state_n = (len_clamp == '0) ? DONE : RD;
        end else if (bus.load_valid) begin
          sram_csb0  = 1'b0;
          sram_web0  = 1'b0;
          sram_addr0 = bus.load_addr;
          sram_din0  = bus.load_data;
          done_n     = 1'b0;
        end
      end
      RD: begin
        sram_csb0  = 1'b0;
        sram_addr0 = idx[ADDR_W-1:0];
        state_n    = abort ? IDLE : CAP;
      end
      CAP: begin
        capture = !abort;
        state_n = abort ? IDLE : VLD;
      end
      VLD: begin
        // abort wins over a same-cycle handshake; that word is not counted
        if (abort) begin
          state_n = IDLE;
        end else if (bus.trace_ready) begin
          cnt_n = cnt + CNT_W'(1);
          idx_n = idx + CNT_W'(1);
          if ((idx + CNT_W'(1)) == len) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = RD;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.load_ready  = load_ready;
  assign bus.trace_valid = (state == VLD);
  assign bus.trace_addr  = word;
  assign busy            = (state == RD) || (state == CAP) || (state == VLD);
  assign done            = done_r;
  assign played_count    = cnt;
endmodule

// File: tb/tb_trace_sram_sequencer.sv
// Self-checking bench: behavioural SRAM, shadow memory as reference, directed and random playback.
module tb_trace_sram_sequencer;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;

  logic clk = 0, reset = 1, start = 0, abort = 0;
  logic [ADDR_W:0] trace_len = '0;
  logic busy, done, sram_csb0, sram_web0;
  logic [ADDR_W:0] played_count;
  logic [ADDR_W-1:0] sram_addr0;
  logic [DATA_W-1:0] sram_din0, sram_dout0;

  trace_sram_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  trace_sram_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .trace_len(trace_len),
    .bus(bus), .busy(busy), .done(done), .played_count(played_count),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  always @(posedge clk)
    if (!sram_csb0) begin
      if (!sram_web0) mem[sram_addr0] <= sram_din0;
      else            sram_dout0 <= mem[sram_addr0];
    end

  int cyc = 0, rd_cnt = 0, wr_cnt = 0, vld_access = 0, last_rd = -1;
  logic [DATA_W-1:0] hs_q[$];
  int hs_cyc[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!reset) begin
      if (bus.trace_valid && bus.trace_ready && !abort) begin
        hs_q.push_back(bus.trace_addr);
        hs_cyc.push_back(cyc);
      end
      if (!sram_csb0 && sram_web0) begin rd_cnt++; last_rd = int'(sram_addr0); end
      if (!sram_csb0 && !sram_web0) wr_cnt++;
      if (bus.trace_valid && !sram_csb0) vld_access++;
    end

  int checks = 0, errors = 0;
  int start_cyc = 0, rd_base = 0, wr_base = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic write_word(input int a, input logic [DATA_W-1:0] d);
    step();
    bus.load_valid = 1; bus.load_addr = ADDR_W'(a); bus.load_data = d;
    #1 check("load_ready_idle", {31'b0, bus.load_ready}, 1);
    step();
    bus.load_valid = 0;
    ref_mem[a] = d;
  endtask

  task automatic kick(input int len);
    hs_q.delete(); hs_cyc.delete(); rd_base = rd_cnt; wr_base = wr_cnt;
    step();
    trace_len = (ADDR_W+1)'(len); start = 1; start_cyc = cyc;
    step();
    start = 0;
  endtask

  task automatic run_to_done(input int pct, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      bus.trace_ready = ($urandom_range(99) < pct);
      step();
      n++;
    end
    check("play_timeout", {31'b0, n < budget}, 1);
    bus.trace_ready = 0;
  endtask

  task automatic check_play(input string tag, input int len);
    int exp_n = (len > DEPTH) ? DEPTH : len;
    check({tag, "_count"}, hs_q.size(), exp_n);
    for (int i = 0; i < exp_n && i < hs_q.size(); i++)
      if (hs_q[i] !== ref_mem[i]) check({tag, "_word"}, hs_q[i], ref_mem[i]);
    check({tag, "_played"}, 32'(played_count), exp_n);
    check({tag, "_done"}, {31'b0, done}, 1);
    check({tag, "_reads"}, rd_cnt - rd_base, exp_n);
  endtask

  initial begin
    logic [DATA_W-1:0] init_words [4];
    init_words[0] = 32'h1000; init_words[1] = 32'h1004;
    init_words[2] = 32'h2000; init_words[3] = 32'h1000;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    bus.load_valid = 0; bus.load_addr = '0; bus.load_data = '0; bus.trace_ready = 0;
    repeat (3) step();
    reset = 0;
    #1;
    check("rst_valid", {31'b0, bus.trace_valid}, 0);
    check("rst_addr", bus.trace_addr, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_played", 32'(played_count), 0);
    check("rst_csb", {31'b0, sram_csb0}, 1);
    check("rst_web", {31'b0, sram_web0}, 1);
    check("rst_load_ready", {31'b0, bus.load_ready}, 1);

    for (int i = 0; i < 4; i++) write_word(i, init_words[i]);

    // basic playback with timing
    kick(4);
    run_to_done(100, 100);
    check_play("basic", 4);
    for (int i = 0; i < 4 && i < hs_cyc.size(); i++)
      check("basic_timing", hs_cyc[i] - start_cyc, 3 * (i + 1));

    // stall on word 2
    begin
      int stall = 5, n = 0, bad = 0;
      kick(4);
      while (!done && n < 200) begin
        if (bus.trace_valid && hs_q.size() == 1 && stall > 0) begin
          bus.trace_ready = 0; stall--;
          if (bus.trace_addr !== 32'h1004) bad++;
        end else bus.trace_ready = 1;
        step(); n++;
      end
      bus.trace_ready = 0;
      check("stall_hold", bad, 0);
      check("stall_used", stall, 0);
      check("stall_no_access", vld_access, 0);
      check_play("stall", 4);
    end

    // zero length
    kick(0);
    check("len0_done", {31'b0, done}, 1);
    check("len0_busy", {31'b0, busy}, 0);
    check("len0_played", 32'(played_count), 0);
    step();
    check("len0_reads", rd_cnt - rd_base, 0);

    // clamped length
    kick(2000);
    run_to_done(100, 4000);
    check_play("clamp", 2000);
    check("clamp_last_rd", last_rd, DEPTH - 1);

    // abort in VLD of word 2 with ready high
    begin
      int n = 0;
      kick(4);
      bus.trace_ready = 1;
      while (!(bus.trace_valid && hs_q.size() == 1) && n < 50) begin step(); n++; end
      abort = 1;
      step();
      abort = 0; bus.trace_ready = 0;
      check("abort_valid", {31'b0, bus.trace_valid}, 0);
      check("abort_busy", {31'b0, busy}, 0);
      check("abort_played", 32'(played_count), 1);
      check("abort_done", {31'b0, done}, 0);
    end

    // start and load together in IDLE: no write, playback starts
    hs_q.delete(); rd_base = rd_cnt; wr_base = wr_cnt;
    step();
    trace_len = 4; start = 1; start_cyc = cyc;
    bus.load_valid = 1; bus.load_addr = 1; bus.load_data = 32'hbeef;
    #1 check("start_load_ready", {31'b0, bus.load_ready}, 0);
    step();
    start = 0;
    // keep requesting a load during playback
    #1 check("busy_load_ready", {31'b0, bus.load_ready}, 0);
    bus.load_addr = 0; bus.load_data = 32'hdead;
    run_to_done(100, 100);
    bus.load_valid = 0;
    check("no_write", wr_cnt - wr_base, 0);
    check_play("contend", 4);

    // reset during CAP, then replay
    kick(4);
    step();
    check("cap_busy", {31'b0, busy}, 1);
    reset = 1;
    step();
    reset = 0;
    check("rstcap_valid", {31'b0, bus.trace_valid}, 0);
    check("rstcap_addr", bus.trace_addr, 0);
    check("rstcap_busy", {31'b0, busy}, 0);
    check("rstcap_done", {31'b0, done}, 0);
    check("rstcap_played", 32'(played_count), 0);
    check("rstcap_csb", {31'b0, sram_csb0}, 1);
    kick(4);
    run_to_done(100, 100);
    check_play("replay", 4);

    // random loads and playbacks
    for (int r = 0; r < 6; r++) begin
      int nw = $urandom_range(3, 10);
      int len = $urandom_range(1, 40);
      for (int w = 0; w < nw; w++) write_word($urandom_range(0, 39), $urandom);
      kick(len);
      run_to_done(60, 1000);
      check_play("rand", len);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
